// File: rtl/universal_register_neg_clk_pkg.sv
// universal_register_neg_clk_pkg: shared mode encodings for the universal register
package universal_register_neg_clk_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_SHL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;
endpackage

// File: rtl/universal_register_slice.sv
// universal_register_slice: one register bit with next-state mux, falling-edge flop and inc/dec ripple
module universal_register_slice
  import universal_register_neg_clk_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en_n,
  input  mode_e mode,
  input  logic  d,
  input  logic  hi,
  input  logic  lo,
  input  logic  ci,
  output logic  q,
  output logic  co
);
  logic nxt;
  always_comb begin
    nxt = q;
    case (mode)
      MODE_LOAD:          nxt = d;
      MODE_SHR, MODE_ROR: nxt = hi;
      MODE_SHL, MODE_ROL: nxt = lo;
      MODE_INC, MODE_DEC: nxt = q ^ ci;
      default:            nxt = q;
    endcase
  end
  assign co = ci & (mode == MODE_DEC ? ~q : q);
  always_ff @(negedge clk) begin
    if (rst) q <= RST_BIT;
    else if (!en_n) q <= nxt;
  end
endmodule

// File: rtl/universal_register_neg_clk.sv
// universal_register_neg_clk: falling-edge universal register with load/shift/rotate/inc/dec, carry and zero flags
module universal_register_neg_clk
  import universal_register_neg_clk_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             Clkbar,
  input  logic             Reset,
  input  logic             Enbar,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] in,
  input  logic             SerInR,
  input  logic             SerInL,
  output logic [WIDTH-1:0] out,
  output logic             Carry,
  output logic             Zero
);
  localparam int N = WIDTH - 1;
  mode_e mode;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH:0] c;
  logic carry_nxt;
  assign mode = mode_e'(Mode);
  assign hi = {(mode == MODE_SHR) ? SerInR : out[0], out[N:1]};
  assign lo = {out[N-1:0], (mode == MODE_SHL) ? SerInL : out[N]};
  assign c[0] = 1'b1;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    universal_register_slice #(.RST_BIT(RESET_VALUE[g])) u_slice (
      .clk  (Clkbar),
      .rst  (Reset),
      .en_n (Enbar),
      .mode (mode),
      .d    (in[g]),
      .hi   (hi[g]),
      .lo   (lo[g]),
      .ci   (c[g]),
      .q    (out[g]),
      .co   (c[g+1])
    );
  end
  always_comb begin
    carry_nxt = Carry;
    case (mode)
      MODE_LOAD:          carry_nxt = 1'b0;
      MODE_SHR, MODE_ROR: carry_nxt = out[0];
      MODE_SHL, MODE_ROL: carry_nxt = out[N];
      MODE_INC, MODE_DEC: carry_nxt = c[WIDTH];
      default:            carry_nxt = Carry;
    endcase
  end
  always_ff @(negedge Clkbar) begin
    if (Reset) Carry <= 1'b0;
    else if (!Enbar) Carry <= carry_nxt;
  end
  assign Zero = ~|out;
endmodule

// File: tb/tb_universal_register_neg_clk.sv
// tb_universal_register_neg_clk: directed vector table plus randomized run against an arithmetic reference model
module tb_universal_register_neg_clk;
  import universal_register_neg_clk_pkg::*;
  logic clk = 1'b1, rst = 1'b0, en_n = 1'b1, sr = 1'b0, sl = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] din = 8'h00, dout;
  logic carry, zero;
  int errors = 0, checks = 0;
  int m_out = 0;
  int m_c = 0;
  typedef struct {
    logic       rst, en_n;
    logic [2:0] mode;
    logic [7:0] din;
    logic       sr, sl;
    logic [7:0] e_out;
    logic       e_c, e_z;
  } vec_t;
  vec_t vecs[$];
  universal_register_neg_clk #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .Clkbar (clk),
    .Reset  (rst),
    .Enbar  (en_n),
    .Mode   (mode),
    .in     (din),
    .SerInR (sr),
    .SerInL (sl),
    .out    (dout),
    .Carry  (carry),
    .Zero   (zero)
  );
  always #5 clk = ~clk;
  function automatic void model(input logic r, e, input logic [2:0] md, input int d, input logic sri, sli);
    if (r) begin
      m_out = 0;
      m_c = 0;
    end else if (!e) begin
      case (md)
        3'd1: begin m_out = d; m_c = 0; end
        3'd2: begin m_c = m_out % 2; m_out = m_out / 2 + (sri ? 128 : 0); end
        3'd3: begin m_c = m_out / 128; m_out = (m_out * 2 + (sli ? 1 : 0)) % 256; end
        3'd4: begin m_c = m_out % 2; m_out = m_out / 2 + m_c * 128; end
        3'd5: begin m_c = m_out / 128; m_out = (m_out * 2 + m_c) % 256; end
        3'd6: begin m_c = (m_out == 255) ? 1 : 0; m_out = (m_out + 1) % 256; end
        3'd7: begin m_c = (m_out == 0) ? 1 : 0; m_out = (m_out + 255) % 256; end
        default: ;
      endcase
    end
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, e, input logic [2:0] md, input logic [7:0] d, input logic sri, sli);
    @(posedge clk);
    rst = r; en_n = e; mode = md; din = d; sr = sri; sl = sli;
    @(negedge clk);
    #1;
    model(r, e, md, int'(d), sri, sli);
  endtask
  task automatic add(input logic r, e, input logic [2:0] md, input logic [7:0] d, input logic sri, sli,
                     input logic [7:0] eo, input logic ec, ez);
    vec_t v;
    v.rst = r; v.en_n = e; v.mode = md; v.din = d; v.sr = sri; v.sl = sli;
    v.e_out = eo; v.e_c = ec; v.e_z = ez;
    vecs.push_back(v);
  endtask
  initial begin
    add(1, 0, MODE_LOAD, 8'hA5, 0, 0, 8'h00, 0, 1);
    add(1, 1, MODE_LOAD, 8'hA5, 0, 0, 8'h00, 0, 1);
    add(0, 0, MODE_LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, MODE_INC, 8'hFF, 0, 0, 8'h3C, 0, 0);
    add(0, 0, MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0, 0);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'hFF, 0, 0);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'h00, 1, 1);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'h01, 0, 0);
    add(0, 0, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 1);
    add(0, 0, MODE_DEC,  8'h00, 0, 0, 8'hFF, 1, 0);
    add(0, 0, MODE_HOLD, 8'h12, 0, 0, 8'hFF, 1, 0);
    add(0, 1, MODE_SHR,  8'h12, 0, 0, 8'hFF, 1, 0);
    add(0, 0, MODE_DEC,  8'h00, 0, 0, 8'hFE, 0, 0);
    add(0, 0, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0);
    add(0, 0, MODE_SHR,  8'h00, 0, 0, 8'h40, 1, 0);
    add(0, 0, MODE_SHL,  8'h00, 0, 1, 8'h81, 0, 0);
    add(0, 0, MODE_ROR,  8'h00, 0, 0, 8'hC0, 1, 0);
    add(0, 0, MODE_ROL,  8'h00, 0, 0, 8'h81, 1, 0);
    add(0, 0, MODE_LOAD, 8'h55, 0, 0, 8'h55, 0, 0);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'h56, 0, 0);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'h57, 0, 0);
    add(1, 1, MODE_INC,  8'h00, 0, 0, 8'h00, 0, 1);
    add(0, 0, MODE_INC,  8'h00, 0, 0, 8'h01, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en_n, vecs[i].mode, vecs[i].din, vecs[i].sr, vecs[i].sl);
      check($sformatf("vec%0d out", i), int'(dout), int'(vecs[i].e_out));
      check($sformatf("vec%0d carry", i), int'(carry), int'(vecs[i].e_c));
      check($sformatf("vec%0d zero", i), int'(zero), int'(vecs[i].e_z));
    end
    step(0, 0, MODE_LOAD, 8'hFD, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, MODE_INC, 8'h00, 0, 0);
      check($sformatf("wrap inc%0d out", i), int'(dout), m_out);
      check($sformatf("wrap inc%0d carry", i), int'(carry), m_c);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, MODE_DEC, 8'h00, 0, 0);
      check($sformatf("wrap dec%0d out", i), int'(dout), m_out);
      check($sformatf("wrap dec%0d carry", i), int'(carry), m_c);
    end
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom), 1'($urandom));
      check($sformatf("rand%0d out", i), int'(dout), m_out);
      check($sformatf("rand%0d carry", i), int'(carry), m_c);
      check($sformatf("rand%0d zero", i), int'(zero), (m_out == 0) ? 1 : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
